// File: rtl/ff_input_pkg.sv
// ff_input_pkg
// Shared definitions for the board-level input conditioning path.
//   state_t            : debounce FSM state encoding
//   DEF_SYNC_STAGES    : default synchronizer depth
//   DEF_STABLE_CYCLES  : default number of equal samples needed to accept a level
package ff_input_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 16;

endpackage

// File: rtl/sync_chain.sv
// sync_chain
// Parameterized flop chain bringing an asynchronous input into the clk domain.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; clears every stage
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  // Bit 0 is the metastability-catching flop; data shifts towards the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse
// Debounces a raw mechanical input and produces a clean level plus
// single-cycle rise/fall pulses for the downstream flip-flop stage.
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high
//   btn_in     : raw asynchronous input (may bounce)
//   enable     : 0 freezes acceptance and aborts any count in progress
//   level      : debounced level (registered)
//   rise_pulse : one cycle high on level 0->1 (registered)
//   fall_pulse : one cycle high on level 1->0 (registered)
//   busy       : high while a candidate transition is being counted
module debounce_pulse
  import ff_input_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic enable,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_pulse_reg;
  logic             fall_pulse_reg;
  logic             busy_reg;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (s)
  );

  // cnt_reg holds the number of consecutive candidate samples already seen,
  // so acceptance happens on the sample that makes the run STABLE_CYCLES long.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_STABLE_LO;
      cnt_reg        <= '0;
      level_reg      <= 1'b0;
      rise_pulse_reg <= 1'b0;
      fall_pulse_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      rise_pulse_reg <= 1'b0;
      fall_pulse_reg <= 1'b0;
      if (!enable) begin
        // Abort any candidate; stable states and level simply hold.
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
        if (state_reg == ST_WAIT_HI) begin
          state_reg <= ST_STABLE_LO;
        end else if (state_reg == ST_WAIT_LO) begin
          state_reg <= ST_STABLE_HI;
        end
      end else begin
        case (state_reg)
          ST_STABLE_LO: begin
            if (s) begin
              state_reg <= ST_WAIT_HI;
              cnt_reg   <= CNT_ONE;
              busy_reg  <= 1'b1;
            end
          end
          ST_WAIT_HI: begin
            if (!s) begin
              state_reg <= ST_STABLE_LO;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg      <= ST_STABLE_HI;
              cnt_reg        <= '0;
              level_reg      <= 1'b1;
              rise_pulse_reg <= 1'b1;
              busy_reg       <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          ST_STABLE_HI: begin
            if (!s) begin
              state_reg <= ST_WAIT_LO;
              cnt_reg   <= CNT_ONE;
              busy_reg  <= 1'b1;
            end
          end
          ST_WAIT_LO: begin
            if (s) begin
              state_reg <= ST_STABLE_HI;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg      <= ST_STABLE_LO;
              cnt_reg        <= '0;
              level_reg      <= 1'b0;
              fall_pulse_reg <= 1'b1;
              busy_reg       <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_reg <= ST_STABLE_LO;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level      = level_reg;
  assign rise_pulse = rise_pulse_reg;
  assign fall_pulse = fall_pulse_reg;
  assign busy       = busy_reg;

endmodule
